coin_score_keeper: RTL and testbench

- Sits directly downstream of the coin placement/collision block.
- Consumes its single-cycle coin-collected pulse and keeps the 3-digit BCD coin score.
- Detects the win condition and drives the board's 4-digit multiplexed 7-segment display.
- Its score and win outputs also feed the game-state/overlay logic.

---
 rtl/coin_score_keeper_pkg.sv | 17 +
 rtl/coin_score_keeper_seg7_decode.sv | 30 +++
 rtl/coin_score_keeper.sv | 177 +++++++++++++++++
 tb/tb_coin_score_keeper.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_score_keeper_pkg.sv
// Shared types and constants for the coin score keeper: FSM states, BCD layout
// and the 7-segment glyphs that are not plain digits.
package coin_score_keeper_pkg;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_WIN  = 1'b1
    } state_t;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 3;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_C     = 7'h46;

endpackage

// File: rtl/coin_score_keeper_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes and the blank
// flag both produce a dark digit.
module coin_score_keeper_seg7_decode
    import coin_score_keeper_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/coin_score_keeper.sv
// Coin score keeper: 3-digit BCD score, PLAY/WIN state machine and a
// multiplexed 4-digit 7-segment display that blinks while the game is won.
module coin_score_keeper
    import coin_score_keeper_pkg::*;
#(
    parameter logic [11:0] WIN_COUNT = 12'h010,
    parameter logic [15:0] SCAN_DIV  = 16'd25000,
    parameter logic [23:0] BLINK_DIV = 24'd6250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reach_coin,
    input  logic        clear,
    output logic [11:0] score_bcd,
    output logic        win,
    output logic        win_pulse,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int SCORE_W = NUM_DIGITS * BCD_W;

    state_t             state_reg, state_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               win_pulse_reg, win_pulse_next;

    // Single-cycle ripple incrementer; carry[NUM_DIGITS] means the score is all nines.
    logic [SCORE_W-1:0]  score_inc;
    logic [NUM_DIGITS:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_bcd_inc
            logic [BCD_W-1:0] cur_digit;
            logic             is_nine;

            assign cur_digit      = score_reg[gi*BCD_W +: BCD_W];
            assign is_nine        = (cur_digit == 4'd9);
            assign carry[gi+1]    = carry[gi] & is_nine;
            assign score_inc[gi*BCD_W +: BCD_W] =
                !carry[gi] ? cur_digit : (is_nine ? 4'd0 : cur_digit + 4'd1);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        score_next     = score_reg;
        win_pulse_next = 1'b0;
        if (clear) begin
            state_next = ST_PLAY;
            score_next = '0;
        end else begin
            case (state_reg)
                ST_PLAY: begin
                    if (reach_coin && !carry[NUM_DIGITS]) begin
                        score_next = score_inc;
                        if (score_inc == WIN_COUNT) begin
                            state_next     = ST_WIN;
                            win_pulse_next = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_PLAY;
            score_reg     <= '0;
            win_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            score_reg     <= score_next;
            win_pulse_reg <= win_pulse_next;
        end
    end

    logic [15:0] scan_cnt_reg, scan_cnt_next;
    logic [1:0]  digit_idx_reg, digit_idx_next;
    logic [23:0] blink_cnt_reg, blink_cnt_next;
    logic        blink_off_reg, blink_off_next;

    always_comb begin
        scan_cnt_next  = scan_cnt_reg + 16'd1;
        digit_idx_next = digit_idx_reg;
        if (scan_cnt_reg == SCAN_DIV - 16'd1) begin
            scan_cnt_next  = '0;
            digit_idx_next = digit_idx_reg + 2'd1;
        end
    end

    // Blink timing is held at its start point whenever the game is not won.
    always_comb begin
        blink_cnt_next = blink_cnt_reg + 24'd1;
        blink_off_next = blink_off_reg;
        if (state_reg != ST_WIN) begin
            blink_cnt_next = '0;
            blink_off_next = 1'b0;
        end else if (blink_cnt_reg == BLINK_DIV - 24'd1) begin
            blink_cnt_next = '0;
            blink_off_next = ~blink_off_reg;
        end
    end

    logic [BCD_W-1:0] mux_digit;
    logic             mux_blank;
    logic [6:0]       dec_seg;
    logic             hundreds_zero, tens_zero;
    logic [6:0]       seg_reg, seg_next;
    logic [3:0]       an_reg, an_next;

    assign hundreds_zero = (score_reg[11:8] == 4'd0);
    assign tens_zero     = (score_reg[7:4] == 4'd0);

    always_comb begin
        mux_digit = score_reg[3:0];
        mux_blank = 1'b0;
        case (digit_idx_reg)
            2'd0: mux_digit = score_reg[3:0];
            2'd1: begin
                mux_digit = score_reg[7:4];
                mux_blank = hundreds_zero && tens_zero;
            end
            2'd2: begin
                mux_digit = score_reg[11:8];
                mux_blank = hundreds_zero;
            end
            default: mux_blank = 1'b1;
        endcase
    end

    coin_score_keeper_seg7_decode u_seg7_decode (
        .digit (mux_digit),
        .blank (mux_blank),
        .seg   (dec_seg)
    );

    // an and seg are registered together so a digit never shows its neighbour's pattern.
    always_comb begin
        seg_next = dec_seg;
        if (digit_idx_reg == 2'd3) begin
            seg_next = (state_reg == ST_WIN) ? SEG_C : SEG_BLANK;
        end
        an_next = ~(4'b0001 << digit_idx_reg);
        if (state_reg == ST_WIN && blink_off_reg) begin
            an_next = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= '0;
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
            seg_reg       <= SEG_BLANK;
            an_reg        <= 4'b1111;
        end else begin
            scan_cnt_reg  <= scan_cnt_next;
            digit_idx_reg <= digit_idx_next;
            blink_cnt_reg <= blink_cnt_next;
            blink_off_reg <= blink_off_next;
            seg_reg       <= seg_next;
            an_reg        <= an_next;
        end
    end

    assign score_bcd = score_reg;
    assign win       = (state_reg == ST_WIN);
    assign win_pulse = win_pulse_reg;
    assign seg       = seg_reg;
    assign an        = an_reg;

endmodule

// File: tb/tb_coin_score_keeper.sv
// Scoreboard bench: two keepers share one random coin/clear stream; a decimal
// reference model predicts every cycle and a monitor compares after each edge.
module tb_coin_score_keeper;

    localparam int SCAN_I  = 4;
    localparam int BLINK_I = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reach_coin = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] score_a, score_b;
    logic        win_a, win_b, pulse_a, pulse_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;

    coin_score_keeper #(
        .WIN_COUNT (12'h010),
        .SCAN_DIV  (16'd4),
        .BLINK_DIV (24'd20)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .reach_coin (reach_coin),
        .clear      (clear),
        .score_bcd  (score_a),
        .win        (win_a),
        .win_pulse  (pulse_a),
        .seg        (seg_a),
        .an         (an_a)
    );

    coin_score_keeper #(
        .WIN_COUNT (12'hFFF),
        .SCAN_DIV  (16'd7),
        .BLINK_DIV (24'd20)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .reach_coin (reach_coin),
        .clear      (clear),
        .score_bcd  (score_b),
        .win        (win_b),
        .win_pulse  (pulse_b),
        .seg        (seg_b),
        .an         (an_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] score_a;
        logic        win_a;
        logic        pulse_a;
        logic [3:0]  an_a;
        logic [6:0]  seg_a;
        logic [11:0] score_b;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: plain decimal scores, edges since reset, WIN streak.
    int sa = 0, sb = 0, k = 0, streak = 0;
    bit wa = 1'b0;

    function automatic logic [11:0] to_bcd(input int s);
        logic [11:0] r;
        r[11:8] = 4'(s / 100);
        r[7:4]  = 4'((s / 10) % 10);
        r[3:0]  = 4'(s % 10);
        return r;
    endfunction

    function automatic logic [6:0] seven(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_glyph(input int idx, input int s, input bit w);
        int h = s / 100;
        int t = (s / 10) % 10;
        int o = s % 10;
        case (idx)
            0: return seven(o);
            1: return (h == 0 && t == 0) ? 7'h7F : seven(t);
            2: return (h == 0) ? 7'h7F : seven(h);
            default: return w ? 7'h46 : 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        sa = 0; sb = 0; k = 0; streak = 0; wa = 1'b0;
    endtask

    // Called at a falling edge: drives inputs, predicts the next rising edge.
    task automatic step(input bit rc, input bit cl);
        exp_t e;
        int   idx;
        bit   blank_now;
        reach_coin = rc;
        clear      = cl;
        idx        = (k / SCAN_I) % 4;
        blank_now  = wa && ((streak / BLINK_I) % 2 == 1);
        e.an_a     = blank_now ? 4'b1111 : ~(4'b0001 << idx);
        e.seg_a    = exp_glyph(idx, sa, wa);
        streak     = wa ? streak + 1 : 0;
        k++;
        e.pulse_a  = 1'b0;
        if (cl) begin
            sa = 0;
            wa = 1'b0;
        end else if (rc && !wa && sa < 999) begin
            sa++;
            if (sa == 10) begin
                wa        = 1'b1;
                e.pulse_a = 1'b1;
            end
        end
        if (cl) sb = 0;
        else if (rc && sb < 999) sb++;
        e.score_a = to_bcd(sa);
        e.win_a   = wa;
        e.score_b = to_bcd(sb);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        check({tag, "_an"},      32'(an_a),    32'hF);
        check({tag, "_seg"},     32'(seg_a),   32'h7F);
        check({tag, "_score_a"}, 32'(score_a), 32'h0);
        check({tag, "_win_a"},   32'(win_a),   32'h0);
        check({tag, "_pulse_a"}, 32'(pulse_a), 32'h0);
        check({tag, "_score_b"}, 32'(score_b), 32'h0);
    endtask

    // Asynchronous reset mid-cycle: outputs must go dark before any clock edge.
    task automatic mid_reset();
        exp_t e;
        reach_coin = 1'b0;
        clear      = 1'b0;
        e.score_a  = 12'h000;
        e.win_a    = 1'b0;
        e.pulse_a  = 1'b0;
        e.an_a     = 4'b1111;
        e.seg_a    = 7'h7F;
        e.score_b  = 12'h000;
        exp_q.push_back(e);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: one transaction per rising edge while predictions are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                check("score_a", 32'(score_a), 32'(e.score_a));
                check("win_a",   32'(win_a),   32'(e.win_a));
                check("pulse_a", 32'(pulse_a), 32'(e.pulse_a));
                check("an_a",    32'(an_a),    32'(e.an_a));
                check("seg_a",   32'(seg_a),   32'(e.seg_a));
                check("score_b", 32'(score_b), 32'(e.score_b));
                check("win_b",   32'(win_b),   32'h0);
                check("pulse_b", 32'(pulse_b), 32'h0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        repeat (7) begin
            step(1, 0); step(0, 0); step(0, 0);
        end
        repeat (3) begin
            step(1, 0); step(0, 0);
        end
        repeat (5) step(1, 0);
        repeat (60) step(1'($urandom_range(0, 1)), 1'b0);

        step(0, 1);
        repeat (5) step(1, 0);
        step(1, 1);
        repeat (4) step(0, 0);

        repeat (300) step(1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);

        step(0, 0);
        step(0, 0);
        mid_reset();

        repeat (1100) step(1, 0);
        step(0, 1);
        repeat (200) step(1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        repeat (3) step(0, 0);

        @(posedge clk);
        #2;
        vectors++;
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
